// File: rtl/codec_pkg.sv
// Shared definitions for the LZS source unpacker and output packer.
// Covers the state encoding, lane geometry and descriptor bit positions.
package codec_pkg;

  localparam int unsigned LANE_W     = 16;
  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned SRC_W      = LANES * LANE_W;
  localparam int unsigned DC_W       = 24;
  localparam int unsigned ENC_BIT    = 5;
  localparam int unsigned DEC_BIT    = 6;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 2'd1;
  localparam logic [STATE_W-1:0] S_SHIFT = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

  // One captured source beat: the data word plus its sideband.
  typedef struct packed {
    logic [SRC_W-1:0]      data;
    logic                  last;
    logic [LANE_IDX_W-1:0] end_lane;
  } src_word_t;

  function automatic logic [LANE_W-1:0] byte_swap(input logic [LANE_W-1:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/lane_mux.sv
// Selects one 16-bit lane from a source word and optionally byte-swaps it.
module lane_mux
  import codec_pkg::*;
(
  input  logic [SRC_W-1:0]      word,
  input  logic [LANE_IDX_W-1:0] idx,
  input  logic                  swap,
  output logic [LANE_W-1:0]     lane_c
);

  logic [LANES-1:0][LANE_W-1:0] lanes_v;
  logic [LANE_W-1:0]            raw;

  always_comb begin
    lanes_v = word;
    raw     = lanes_v[idx];
    lane_c  = swap ? byte_swap(raw) : raw;
  end

endmodule

// File: rtl/codein.sv
// Source-side unpacker: pops 64-bit words from the source FIFO and presents
// them lane by lane to the encoder or decoder under valid/ready.
module codein
  import codec_pkg::*;
#(
  parameter bit SWAP_DECODE = 1'b1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [DC_W-1:0]       dc,
  input  logic                  m_enable,
  input  logic [SRC_W-1:0]      m_src,
  input  logic                  m_src_empty,
  input  logic                  m_src_last,
  input  logic [LANE_IDX_W-1:0] m_src_lanes,
  output tri                    m_src_getn,
  output logic [LANE_W-1:0]     in_data,
  output logic                  en_in_valid,
  output logic                  de_in_valid,
  input  logic                  en_in_ready,
  input  logic                  de_in_ready,
  output logic                  in_last,
  output logic                  in_done
);

  logic                  sel;
  logic                  rdy;
  logic                  hs;
  logic                  at_end;
  logic                  pop_c;
  logic [STATE_W-1:0]    state, state_n;
  logic [LANE_IDX_W-1:0] lane, lane_n;
  src_word_t             hold, hold_n;
  logic                  mode_enc, mode_n;
  logic [LANE_W-1:0]     data_n;
  logic                  en_v_n, de_v_n, last_n, done_n;
  logic                  unused_dc;

  assign sel       = m_enable & (dc[ENC_BIT] | dc[DEC_BIT]);
  assign rdy       = mode_enc ? en_in_ready : de_in_ready;
  assign hs        = sel & (state == S_SHIFT) & rdy;
  assign at_end    = (lane == hold.end_lane);
  assign unused_dc = ^{dc[DC_W-1:DEC_BIT+1], dc[ENC_BIT-1:0]};

  // The pop strobe must be combinational so the final-lane handshake can
  // prefetch the next word in the same cycle; it floats when unselected.
  assign m_src_getn = sel ? ~(pop_c & wb_rst_i) : 1'bz;

  always_comb begin
    state_n = state;
    lane_n  = lane;
    hold_n  = hold;
    mode_n  = mode_enc;
    pop_c   = 1'b0;
    if (!sel) begin
      state_n = S_IDLE;
      lane_n  = '0;
      hold_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!m_src_empty) begin
            pop_c   = 1'b1;
            state_n = S_FETCH;
          end
        end
        S_FETCH: begin
          hold_n  = '{data: m_src, last: m_src_last, end_lane: m_src_lanes};
          lane_n  = '0;
          mode_n  = dc[ENC_BIT];
          state_n = S_SHIFT;
        end
        S_SHIFT: begin
          if (hs) begin
            if (!at_end) begin
              lane_n = lane + LANE_IDX_W'(1);
            end else if (hold.last) begin
              state_n = S_DONE;
            end else if (!m_src_empty) begin
              pop_c   = 1'b1;
              state_n = S_FETCH;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_DONE:  state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they track state exactly.
  always_comb begin
    en_v_n = (state_n == S_SHIFT) & mode_n;
    de_v_n = (state_n == S_SHIFT) & ~mode_n;
    last_n = (state_n == S_SHIFT) & hold_n.last & (lane_n == hold_n.end_lane);
    done_n = (state_n == S_DONE);
  end

  lane_mux u_lane_mux (
    .word   (hold_n.data),
    .idx    (lane_n),
    .swap   (SWAP_DECODE & ~mode_n),
    .lane_c (data_n)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= S_IDLE;
      lane        <= '0;
      hold        <= '0;
      mode_enc    <= 1'b1;
      in_data     <= '0;
      en_in_valid <= 1'b0;
      de_in_valid <= 1'b0;
      in_last     <= 1'b0;
      in_done     <= 1'b0;
    end else begin
      state       <= state_n;
      lane        <= lane_n;
      hold        <= hold_n;
      mode_enc    <= mode_n;
      in_data     <= data_n;
      en_in_valid <= en_v_n;
      de_in_valid <= de_v_n;
      in_last     <= last_n;
      in_done     <= done_n;
    end
  end

endmodule

// File: tb/tb_codein.sv
// Directed bench for codein: a small source FIFO model, a handshake logger,
// a table of single-word vectors and hand-written multi-cycle sequences.
module tb_codein;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [23:0] dc = '0;
  logic        m_enable = 1'b0;
  logic [63:0] m_src = '0;
  logic        m_src_empty;
  logic        m_src_last = 1'b0;
  logic [1:0]  m_src_lanes = '0;
  wire         m_src_getn;
  logic [15:0] in_data;
  logic        en_in_valid, de_in_valid, in_last, in_done;
  logic        en_in_ready = 1'b1;
  logic        de_in_ready = 1'b1;
  logic        flush = 1'b0;

  codein #(.SWAP_DECODE(1'b1)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .dc          (dc),
    .m_enable    (m_enable),
    .m_src       (m_src),
    .m_src_empty (m_src_empty),
    .m_src_last  (m_src_last),
    .m_src_lanes (m_src_lanes),
    .m_src_getn  (m_src_getn),
    .in_data     (in_data),
    .en_in_valid (en_in_valid),
    .de_in_valid (de_in_valid),
    .en_in_ready (en_in_ready),
    .de_in_ready (de_in_ready),
    .in_last     (in_last),
    .in_done     (in_done)
  );

  logic tb_sel;
  assign tb_sel = m_enable & (dc[5] | dc[6]);

  // Source FIFO model: data appears the cycle after a pop.
  logic [66:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_empty = 0;
  assign m_src_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (tb_sel && rst_n && m_src_getn === 1'b0) begin
      if (rd_ptr == wr_ptr) begin
        pop_empty <= pop_empty + 1;
      end else begin
        {m_src_last, m_src_lanes, m_src} <= mem[rd_ptr[3:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake / pop logger and protocol monitors, sampled mid-cycle.
  logic [15:0] log_data [256];
  logic        log_last [256];
  logic        log_enc  [256];
  int          log_cyc  [256];
  int          getn_cyc [256];
  int hs_cnt = 0, getn_cnt = 0, both_err = 0, stable_err = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = '0;

  always @(negedge clk) begin
    if (rst_n && tb_sel && m_src_getn === 1'b0) begin
      getn_cyc[getn_cnt[7:0]] <= cyc;
      getn_cnt <= getn_cnt + 1;
    end
    if (rst_n && tb_sel && ((en_in_valid && en_in_ready) || (de_in_valid && de_in_ready))) begin
      log_data[hs_cnt[7:0]] <= in_data;
      log_last[hs_cnt[7:0]] <= in_last;
      log_enc[hs_cnt[7:0]]  <= en_in_valid;
      log_cyc[hs_cnt[7:0]]  <= cyc;
      hs_cnt <= hs_cnt + 1;
    end
    if (en_in_valid && de_in_valid) both_err <= both_err + 1;
    if (rst_n && tb_sel && pv && !pr && (!(en_in_valid || de_in_valid) || in_data != pd))
      stable_err <= stable_err + 1;
    pv <= rst_n & tb_sel & (en_in_valid | de_in_valid);
    pr <= en_in_valid ? en_in_ready : de_in_ready;
    pd <= in_data;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w, input logic last, input logic [1:0] lanes);
    mem[wr_ptr[3:0]] = {last, lanes, w};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_enable = 1'b0;
    dc = '0;
    en_in_ready = 1'b1;
    de_in_ready = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    logic seen;
    seen = 1'b0;
    done_cyc = -1;
    for (int t = 0; t < budget && !seen; t++) begin
      tick();
      if (in_done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", 64'(seen), 64'(1));
  endtask

  task automatic wait_valid(input int budget);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      if (en_in_valid || de_in_valid) seen = 1'b1;
      else tick();
    end
    check("valid_seen", 64'(seen), 64'(1));
  endtask

  typedef struct {
    logic            enc;
    logic [63:0]     word;
    logic [1:0]      lanes;
    int              n;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vecs [7];
  int hb, gb, dcyc, idx;
  logic [63:0] w;

  initial begin
    vecs[0] = '{1'b1, 64'h4444_3333_2222_1111, 2'd3, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[1] = '{1'b0, 64'h4444_3333_2222_1111, 2'd3, 4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[2] = '{1'b0, 64'h0807_0605_0403_0201, 2'd3, 4, {16'h0708, 16'h0506, 16'h0304, 16'h0102}};
    vecs[3] = '{1'b1, 64'h0807_0605_0403_0201, 2'd3, 4, {16'h0807, 16'h0605, 16'h0403, 16'h0201}};
    vecs[4] = '{1'b1, 64'h0807_0605_0403_0201, 2'd1, 2, {16'h0000, 16'h0000, 16'h0403, 16'h0201}};
    vecs[5] = '{1'b1, 64'hDEAD_BEEF_CAFE_1234, 2'd0, 1, {16'h0000, 16'h0000, 16'h0000, 16'h1234}};
    vecs[6] = '{1'b0, 64'hAABB_CCDD_EEFF_0011, 2'd2, 3, {16'h0000, 16'hDDCC, 16'hFFEE, 16'h1100}};

    // Reset state with the unit selected and data waiting.
    do_reset();
    push(64'h1, 1'b1, 2'd0);
    rst_n = 1'b0;
    dc = 24'h20;
    m_enable = 1'b1;
    tick();
    tick();
    check("rst_en_valid", 64'(en_in_valid), 64'(0));
    check("rst_de_valid", 64'(de_in_valid), 64'(0));
    check("rst_last", 64'(in_last), 64'(0));
    check("rst_done", 64'(in_done), 64'(0));
    check("rst_data", 64'(in_data), 64'(0));
    check("rst_getn", 64'(m_src_getn), 64'(1));

    // Single-word table.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      push(vecs[i].word, 1'b1, vecs[i].lanes);
      hb = hs_cnt;
      gb = getn_cnt;
      dc = vecs[i].enc ? 24'h20 : 24'h40;
      m_enable = 1'b1;
      wait_done(30, dcyc);
      check("vec_nlanes", 64'(hs_cnt - hb), 64'(vecs[i].n));
      for (int k = 0; k < vecs[i].n; k++) begin
        idx = hb + k;
        check("vec_data", 64'(log_data[idx[7:0]]), 64'(vecs[i].exp[k]));
        check("vec_last", 64'(log_last[idx[7:0]]), 64'(k == vecs[i].n - 1));
        check("vec_engine", 64'(log_enc[idx[7:0]]), 64'(vecs[i].enc));
      end
      idx = hb + vecs[i].n - 1;
      check("vec_done_lat", 64'(dcyc - log_cyc[idx[7:0]]), 64'(1));
      check("vec_pops", 64'(getn_cnt - gb), 64'(1));
      m_enable = 1'b0;
      tick();
      check("vec_done_clr", 64'(in_done), 64'(0));
    end

    // Three back-to-back words with a never-empty FIFO.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      w = {16'(k * 16 + 3), 16'(k * 16 + 2), 16'(k * 16 + 1), 16'(k * 16)};
      push(w, k == 3, 2'd3);
    end
    hb = hs_cnt;
    gb = getn_cnt;
    dc = 24'h20;
    m_enable = 1'b1;
    wait_done(40, dcyc);
    check("b2b_pops", 64'(getn_cnt - gb), 64'(3));
    check("b2b_nlanes", 64'(hs_cnt - hb), 64'(12));
    for (int n = 0; n < 12; n++) begin
      idx = hb + n;
      check("b2b_data", 64'(log_data[idx[7:0]]), 64'((n / 4 + 1) * 16 + n % 4));
      check("b2b_last", 64'(log_last[idx[7:0]]), 64'(n == 11));
    end
    idx = hb + 11;
    check("b2b_span", 64'(log_cyc[idx[7:0]] - getn_cyc[gb[7:0]]), 64'(15));
    check("b2b_first_lat", 64'(log_cyc[hb[7:0]] - getn_cyc[gb[7:0]]), 64'(2));

    // Backpressure: ready 1,0,0,1 during SHIFT.
    do_reset();
    push(64'h4444_3333_2222_1111, 1'b1, 2'd3);
    hb = hs_cnt;
    en_in_ready = 1'b0;
    dc = 24'h20;
    m_enable = 1'b1;
    wait_valid(10);
    en_in_ready = 1'b1;
    tick();
    en_in_ready = 1'b0;
    check("bp_hold_data0", 64'(in_data), 64'(16'h2222));
    check("bp_hold_valid0", 64'(en_in_valid), 64'(1));
    tick();
    check("bp_hold_data1", 64'(in_data), 64'(16'h2222));
    check("bp_hold_valid1", 64'(en_in_valid), 64'(1));
    en_in_ready = 1'b1;
    wait_done(20, dcyc);
    check("bp_nlanes", 64'(hs_cnt - hb), 64'(4));
    for (int k = 0; k < 4; k++) begin
      idx = hb + k;
      check("bp_data", 64'(log_data[idx[7:0]]), 64'((k + 1) * 16'h1111));
    end

    // Empty FIFO at a word boundary parks, then resumes in order.
    do_reset();
    push(64'h0004_0003_0002_0001, 1'b0, 2'd3);
    hb = hs_cnt;
    gb = getn_cnt;
    dc = 24'h20;
    m_enable = 1'b1;
    for (int t = 0; t < 12; t++) tick();
    check("park_nlanes", 64'(hs_cnt - hb), 64'(4));
    check("park_valid", 64'(en_in_valid), 64'(0));
    check("park_pops", 64'(getn_cnt - gb), 64'(1));
    push(64'h0008_0007_0006_0005, 1'b1, 2'd1);
    wait_done(20, dcyc);
    check("park_total", 64'(hs_cnt - hb), 64'(6));
    for (int k = 0; k < 6; k++) begin
      idx = hb + k;
      check("park_data", 64'(log_data[idx[7:0]]), 64'(k + 1));
      check("park_last", 64'(log_last[idx[7:0]]), 64'(k == 5));
    end

    // Abort: m_enable dropped mid-word.
    do_reset();
    push(64'h4444_3333_2222_1111, 1'b1, 2'd3);
    push(64'h8888_7777_6666_5555, 1'b1, 2'd3);
    gb = getn_cnt;
    en_in_ready = 1'b0;
    dc = 24'h20;
    m_enable = 1'b1;
    wait_valid(10);
    tick();
    m_enable = 1'b0;
    tick();
    check("abort_en_valid", 64'(en_in_valid), 64'(0));
    check("abort_de_valid", 64'(de_in_valid), 64'(0));
    tick();
    tick();
    check("abort_pops", 64'(getn_cnt - gb), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    en_in_ready = 1'b1;
    m_enable = 1'b1;
    for (int t = 0; t < 3; t++) tick();
    check("abort_idle", 64'(en_in_valid), 64'(0));
    m_enable = 1'b0;

    // Reset asserted while a single-lane final word waits in SHIFT.
    do_reset();
    push(64'h0000_0000_0000_ABCD, 1'b1, 2'd0);
    push(64'h0000_0000_0000_1234, 1'b1, 2'd0);
    gb = getn_cnt;
    en_in_ready = 1'b0;
    dc = 24'h20;
    m_enable = 1'b1;
    wait_valid(10);
    check("mid_last", 64'(in_last), 64'(1));
    check("mid_data", 64'(in_data), 64'(16'hABCD));
    rst_n = 1'b0;
    tick();
    check("mrst_valid", 64'(en_in_valid), 64'(0));
    check("mrst_last", 64'(in_last), 64'(0));
    check("mrst_done", 64'(in_done), 64'(0));
    check("mrst_data", 64'(in_data), 64'(0));
    check("mrst_getn", 64'(m_src_getn), 64'(1));
    tick();
    check("mrst_pops", 64'(getn_cnt - gb), 64'(1));
    do_reset();

    check("no_both_valid", 64'(both_err), 64'(0));
    check("no_pop_empty", 64'(pop_empty), 64'(0));
    check("valid_stable", 64'(stable_err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failed %0d of %0d", n_fail, n_tests);
    $fatal(1);
  end

endmodule
